// File: rtl/alu_operand_loader.sv
// Operand loader for the 4-bit ALU: a debounced KEY steps through A, B and opcode entry, then holds them with valid.
// Define ALU_LOADER_DEBOUNCE_EN to build the debounce counter; otherwise btn_d follows the synchronized button.
module alu_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [2:0]       op_sw,
  input  logic             btn_n,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       op,
  output logic             valid,
  output logic             load_pulse,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic btn_prev_q, btn_prev_d;
  logic btn_d;
  logic press;

  always_comb begin
    sync1_d    = btn_n;
    sync2_d    = sync1_q;
    btn_prev_d = btn_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_prev_q <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_db_q, btn_db_d;

  // The new level is taken on the edge where the differing run would bring the count to DEBOUNCE_CYCLES-1.
  always_comb begin
    cnt_d    = cnt_q;
    btn_db_d = btn_db_q;
    if (sync2_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      btn_db_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      btn_db_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  assign btn_d = btn_db_q;
`else
  assign btn_d = sync2_q;
`endif

  assign press = btn_prev_q & ~btn_d;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             valid_q, valid_d;
  logic             load_q, load_d;
  logic             err_q, err_d;

  // Entry sequencer: every debounced press advances one step; opcode 3'b111 is refused in place.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    load_d  = 1'b0;
    err_d   = err_q;
    if (press) begin
      case (state_q)
        S_A: begin
          a_d     = sw;
          err_d   = 1'b0;
          state_d = S_B;
        end
        S_B: begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: begin
          if (op_sw == 3'b111) begin
            err_d = 1'b1;
          end else begin
            op_d    = op_sw;
            valid_d = 1'b1;
            load_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          valid_d = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign op         = op_q;
  assign valid      = valid_q;
  assign load_pulse = load_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule
